// File: rtl/mips_cpu_run_monitor_if.sv
// Host/CPU-side signal bundle for mips_cpu_run_monitor.
// The master side drives start and CPU observations; the slave (monitor) returns CPU control and run status.
interface mips_cpu_run_monitor_if #(
  parameter int unsigned N_CH  = 1,
  parameter int unsigned CNT_W = 16
) ();
  logic                  start;
  logic [N_CH-1:0]       cpu_active;
  logic [32*N_CH-1:0]    cpu_register_v0;
  logic                  cpu_reset;
  logic                  cpu_clk_enable;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [N_CH-1:0]       halted;
  logic [N_CH-1:0]       no_active_err;
  logic [32*N_CH-1:0]    result_v0;
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W*N_CH-1:0] halt_cycle;

  modport master (
    output start, cpu_active, cpu_register_v0,
    input  cpu_reset, cpu_clk_enable, busy, done, timeout, halted,
           no_active_err, result_v0, cycle_count, halt_cycle
  );

  modport slave (
    input  start, cpu_active, cpu_register_v0,
    output cpu_reset, cpu_clk_enable, busy, done, timeout, halted,
           no_active_err, result_v0, cycle_count, halt_cycle
  );
endinterface

// File: rtl/mips_cpu_run_monitor.sv
// Run controller for N_CH mips_cpu_harvard cores: reset sequencing, timeout, halt capture of v0.
// Define RUN_MONITOR_HALT_CYCLE_EN to build the per-channel halt_cycle registers (otherwise tied to 0).
module mips_cpu_run_monitor #(
  parameter int unsigned N_CH           = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned RESET_CYCLES   = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_run_monitor_if.slave bus
);
  localparam int unsigned      V0_W     = 32;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RSTHOLD, S_WAIT, S_RUN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc_c;
  logic [N_CH-1:0]       pend_q, pend_d;
  logic [N_CH-1:0]       halted_q, halted_d;
  logic [N_CH-1:0]       noact_q, noact_d;
  logic [V0_W*N_CH-1:0]  v0_q, v0_d;
  logic                  timeout_q, timeout_d;
  logic                  done_q, done_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  clk_en_q, clk_en_d;
  logic                  busy_q, busy_d;

  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, capture and output decode; outputs are registered from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    halted_d  = halted_q;
    noact_d   = noact_q;
    v0_d      = v0_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RSTHOLD;
          cnt_d     = '0;
          pend_d    = '0;
          halted_d  = '0;
          noact_d   = '0;
          v0_d      = '0;
          timeout_d = 1'b0;
        end
      end
      S_RSTHOLD: begin
        cnt_d = cnt_inc_c;
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d   = cnt_inc_c;
        pend_d  = ~bus.cpu_active;
        noact_d = ~bus.cpu_active;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc_c;
        // A pending channel captures v0 one edge after its halt was seen.
        for (int i = 0; i < N_CH; i++) begin
          if (pend_q[i]) begin
            v0_d[V0_W*i +: V0_W] = bus.cpu_register_v0[V0_W*i +: V0_W];
            halted_d[i]          = 1'b1;
            pend_d[i]            = 1'b0;
          end else if (!halted_q[i] && !bus.cpu_active[i]) begin
            pend_d[i] = 1'b1;
          end
        end
        if (&halted_q) begin
          state_d = S_DONE;
        end else if ((cnt_inc_c == TMO_LAST) && !(&halted_d)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_d = (state_d == S_IDLE) || (state_d == S_RSTHOLD);
    clk_en_d    = (state_d == S_RSTHOLD) || (state_d == S_WAIT) || (state_d == S_RUN);
    busy_d      = clk_en_d;
    done_d      = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      halted_q    <= '0;
      noact_q     <= '0;
      v0_q        <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      halted_q    <= halted_d;
      noact_q     <= noact_d;
      v0_q        <= v0_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      cpu_reset_q <= cpu_reset_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
    end
  end

`ifdef RUN_MONITOR_HALT_CYCLE_EN
  logic [CNT_W*N_CH-1:0] hc_q, hc_d;
  logic [N_CH-1:0]       cap_c;
  logic                  clr_c;

  assign cap_c = pend_q & {N_CH{state_q == S_RUN}};
  assign clr_c = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Halt cycle records the post-edge cycle count at the capture edge.
  always_comb begin
    hc_d = hc_q;
    if (clr_c) hc_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cap_c[i]) hc_d[CNT_W*i +: CNT_W] = cnt_inc_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hc_q <= '0;
    else        hc_q <= hc_d;
  end

  assign bus.halt_cycle = hc_q;
`else
  assign bus.halt_cycle = '0;
`endif

  assign bus.cpu_reset      = cpu_reset_q;
  assign bus.cpu_clk_enable = clk_en_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_q;
  assign bus.halted         = halted_q;
  assign bus.no_active_err  = noact_q;
  assign bus.result_v0      = v0_q;
  assign bus.cycle_count    = cnt_q;
endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Self-checking bench for mips_cpu_run_monitor: edge-indexed run model plus directed literal pins.
module tb_mips_cpu_run_monitor;
  localparam int unsigned N_CH  = 2;
  localparam int unsigned T     = 20;
  localparam int unsigned R     = 1;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic reset;

  mips_cpu_run_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  mips_cpu_run_monitor #(
    .N_CH(N_CH), .TIMEOUT_CYCLES(T), .RESET_CYCLES(R), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: k = edges since the accepted start; each channel's first-low edge and capture edge.
  int          mk;
  bit          mrun, mended, mdone, mtmo;
  bit [1:0]    mhalt, mnoact;
  logic [31:0] mv0 [2];
  int          mhc [2];
  int          mfirst [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mk = 0; mrun = 0; mended = 0; mdone = 0; mtmo = 0; mhalt = '0; mnoact = '0;
    for (int i = 0; i < 2; i++) begin
      mv0[i] = '0; mhc[i] = 0; mfirst[i] = -1;
    end
  endfunction

  function automatic void model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    mdone = 0;
    if (!mrun) begin
      if (bus.start) begin
        model_reset();
        mrun = 1;
      end
      return;
    end
    mk++;
    if (mk == int'(R) + 1) begin
      for (int i = 0; i < 2; i++)
        if (!bus.cpu_active[i]) begin mnoact[i] = 1; mfirst[i] = mk; end
    end else if (mk >= int'(R) + 2) begin
      if (&mhalt) begin
        mrun = 0; mended = 1; mdone = 1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!mhalt[i]) begin
            if (mfirst[i] >= 0) begin
              if (mk == mfirst[i] + 1) begin
                mhalt[i] = 1;
                mv0[i]   = bus.cpu_register_v0[32*i +: 32];
                mhc[i]   = mk;
              end
            end else if (!bus.cpu_active[i]) begin
              mfirst[i] = mk;
            end
          end
        end
        if (mk == int'(T) - 1 && !(&mhalt)) begin
          mtmo = 1; mrun = 0; mended = 1; mdone = 1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [CNT_W*N_CH-1:0] exp_hc;
`ifdef RUN_MONITOR_HALT_CYCLE_EN
    exp_hc = {CNT_W'(mhc[1]), CNT_W'(mhc[0])};
`else
    exp_hc = '0;
`endif
    chk("busy",          bus.busy,           mrun);
    chk("cpu_reset",     bus.cpu_reset,      mrun ? (mk < int'(R)) : !mended);
    chk("cpu_clk_en",    bus.cpu_clk_enable, mrun);
    chk("done",          bus.done,           mdone);
    chk("timeout",       bus.timeout,        mtmo);
    chk("halted",        bus.halted,         mhalt);
    chk("no_active_err", bus.no_active_err,  mnoact);
    chk("result_v0",     bus.result_v0,      {mv0[1], mv0[0]});
    chk("cycle_count",   bus.cycle_count,    CNT_W'(mk));
    chk("halt_cycle",    bus.halt_cycle,     exp_hc);
  endtask

  // d<0: channel never halts; otherwise active is first sampled low at edge R+d+1.
  task automatic drive(input int d0, input int d1, input bit rnd,
                       input logic [31:0] va, input logic [31:0] vb, input bit st);
    logic a;
    int   d;
    bus.start = st;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? d0 : d1;
      if (!mrun)                            a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else if (d < 0 || mk < int'(R) + d)   a = 1'b1;
      else                                  a = (rnd && mhalt[i]) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cpu_active[i] = a;
    end
    bus.cpu_register_v0 = rnd ? {$urandom, $urandom} : {vb, va};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); model_step();
      @(negedge clk); compare_all();
      drive(-1, -1, 1'b1, '0, '0, 1'b0);
    end
  endtask

  task automatic run_case(input int d0, input int d1, input bit rnd,
                          input logic [31:0] va, input logic [31:0] vb, input int extra_k,
                          output int dones, output logic [CNT_W-1:0] cc_done);
    int cyc;
    bit fin, st;
    cyc = 0; fin = 0; dones = 0; cc_done = '0;
    drive(d0, d1, rnd, va, vb, 1'b1);
    while (!fin && cyc < 80) begin
      @(posedge clk); model_step();
      @(negedge clk); compare_all();
      if (bus.done) begin dones++; cc_done = bus.cycle_count; end
      fin = mended && !mdone;
      st  = mrun && ((extra_k >= 0 && mk == extra_k) || (rnd && $urandom_range(0, 15) == 0));
      drive(d0, d1, rnd, va, vb, st);
      cyc++;
    end
    chk("run_within_budget", fin, 1);
  endtask

  task automatic reset_mid_run(input int after);
    int dn;
    drive(-1, -1, 1'b1, '0, '0, 1'b1);
    repeat (after) begin
      @(posedge clk); model_step();
      @(negedge clk); compare_all();
      drive(-1, -1, 1'b1, '0, '0, 1'b0);
    end
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    chk("midrst_busy",      bus.busy,      0);
    chk("midrst_cpu_reset", bus.cpu_reset, 1);
    chk("midrst_result",    bus.result_v0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(-1, -1, 1'b1, '0, '0, 1'b0);
    dn = 0;
    repeat (5) begin
      @(posedge clk); model_step();
      @(negedge clk); compare_all();
      if (bus.done) dn++;
      drive(-1, -1, 1'b1, '0, '0, 1'b0);
    end
    chk("no_done_after_release", dn, 0);
  endtask

  initial begin
    int               dones, d0, d1;
    logic [CNT_W-1:0] cc;
    logic [31:0]      exp_hc0;
    logic [CNT_W*N_CH-1:0] exp_hc2;

    reset = 1'b0;
    model_reset();
    drive(-1, -1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_clk_en",    bus.cpu_clk_enable, 0);
    reset = 1'b1;
    idle(3);

    // Halt on ch0 with a stray start mid-run, then the identical rerun from DONE.
`ifdef RUN_MONITOR_HALT_CYCLE_EN
    exp_hc0 = 32'd13;
    exp_hc2 = {16'd15, 16'd8};
`else
    exp_hc0 = 32'd0;
    exp_hc2 = '0;
`endif
    for (int rep = 0; rep < 2; rep++) begin
      run_case(10, 3, 1'b0, 32'h0000_1234, 32'h0000_0055, (rep == 0) ? 6 : -1, dones, cc);
      chk("halt_done_pulses", dones, 1);
      chk("halt_halted",      bus.halted, 2'b11);
      chk("halt_v0_ch0",      bus.result_v0[31:0], 32'h0000_1234);
      chk("halt_timeout",     bus.timeout, 0);
      chk("halt_cycle_ch0",   bus.halt_cycle[15:0], exp_hc0[15:0]);
    end

    run_case(-1, -1, 1'b0, 32'h1111_1111, 32'h2222_2222, -1, dones, cc);
    chk("tmo_timeout",    bus.timeout, 1);
    chk("tmo_done_count", cc, 19);
    chk("tmo_halted",     bus.halted, 0);
    chk("tmo_result",     bus.result_v0, 0);
    chk("tmo_clk_en",     bus.cpu_clk_enable, 0);

    run_case(0, 0, 1'b0, 32'hCAFE_0001, 32'hCAFE_0002, -1, dones, cc);
    chk("noact_err",     bus.no_active_err, 2'b11);
    chk("noact_halted",  bus.halted, 2'b11);
    chk("noact_result",  bus.result_v0, 64'hCAFE_0002_CAFE_0001);
    chk("noact_timeout", bus.timeout, 0);

    run_case(5, 12, 1'b0, 32'h0000_000A, 32'h0000_000B, -1, dones, cc);
    chk("two_result",     bus.result_v0, 64'h0000_000B_0000_000A);
    chk("two_halt_cycle", bus.halt_cycle, exp_hc2);
    chk("two_done_count", dones, 1);

    reset_mid_run(8);

    for (int n = 0; n < 25; n++) begin
      d0 = int'($urandom_range(0, 23)) - 1;
      d1 = int'($urandom_range(0, 23)) - 1;
      run_case(d0, d1, 1'b1, '0, '0, -1, dones, cc);
      chk("rand_done_pulses", dones, 1);
      idle(int'($urandom_range(0, 3)));
      if (n == 12) reset_mid_run(int'($urandom_range(3, 12)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_cpu_run_monitor.md
# mips_cpu_run_monitor

Synthesizable run controller for one or more `mips_cpu_harvard` instances. It sequences CPU reset, enforces a cycle timeout, and detects each CPU's halt from its `active` output. One cycle after each halt it captures that CPU's `register_v0` and reports the run status. It sits between a host or test sequencer and N_CH CPU cores sharing one clock, replacing hand-written per-test reset and timeout logic.

## Interface
- N_CH, 1: number of CPU channels monitored
- TIMEOUT_CYCLES, 100: run-length limit in cycles; must be ≥ RESET_CYCLES+3
- RESET_CYCLES, 1: cycles `cpu_reset` is held high after start
- CNT_W, 16: cycle counter width; must hold TIMEOUT_CYCLES
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low forces every register to its reset value immediately
- start  in  1  run request; sampled only in IDLE or DONE
- cpu_active  in  N_CH  per-channel CPU `active`
- cpu_register_v0  in  32*N_CH  per-channel `register_v0`; channel i is bits [32i+31:32i]
- cpu_reset  out  1  active-high reset to all CPUs
- cpu_clk_enable  out  1  clock enable to all CPUs
- busy  out  1  high in RSTHOLD, WAIT_ACTIVE and RUN
- done  out  1  one-cycle pulse on entry to DONE
- timeout  out  1  sticky: run ended by timeout
- halted  out  N_CH  sticky per channel: halt detected and v0 captured
- no_active_err  out  N_CH  sticky per channel: `active` was low in WAIT_ACTIVE
- result_v0  out  32*N_CH  captured v0 per channel
- cycle_count  out  CNT_W  cycles since start accepted
- halt_cycle  out  CNT_W*N_CH  cycle_count value at each channel's capture

## Operation
- Reset values while `reset` is low:
  - State is IDLE.
  - `cpu_reset`=1 and `cpu_clk_enable`=0.
  - All other outputs are 0.
- IDLE:
  - `cpu_reset`=1, `cpu_clk_enable`=0.
  - `start`=1 → RSTHOLD. This clears cycle_count, timeout, halted, no_active_err, result_v0, halt_cycle and every per-channel pending flag.
- RSTHOLD:
  - `cpu_reset`=1, `cpu_clk_enable`=1.
  - Lasts RESET_CYCLES cycles, then → WAIT_ACTIVE.
- WAIT_ACTIVE:
  - `cpu_reset`=0, `cpu_clk_enable`=1.
  - Lasts exactly one cycle.
  - Each channel with `cpu_active[i]`=0 gets no_active_err[i]=1 and its pending flag set.
  - → RUN.
- RUN:
  - `cpu_reset`=0, `cpu_clk_enable`=1.
  - A channel that is not halted, not pending, and has `cpu_active[i]`=0 sets its pending flag.
  - On the next edge, a pending channel:
    - captures `cpu_register_v0[i]` into result_v0[i];
    - loads halt_cycle[i] with the updated cycle_count;
    - sets halted[i] and clears pending.
  - All channels halted → DONE.
  - Timeout fires when cycle_count == TIMEOUT_CYCLES-1 and at least one channel is neither halted nor capturing on this edge. Timeout sets timeout=1 and → DONE.
  - Unhalted channels keep result_v0=0 and halted=0.
- DONE:
  - `cpu_reset`=0, `cpu_clk_enable`=0, so CPU state stays frozen for inspection.
  - `done` pulses for one cycle on entry.
  - Results hold until `start` → RSTHOLD, with the same clearing as from IDLE.
- cycle_count increments on every edge while `busy` and saturates at all-ones. It holds its value in DONE.
- `start` while `busy` is ignored.
- `cpu_active` rising again after a channel has halted is ignored.

## Timing
- Start accepted at edge E0 → `busy`=1 and `cpu_reset`=1 from E0 onward.
- `cpu_reset` falls at edge E(RESET_CYCLES). WAIT_ACTIVE samples at edge E(RESET_CYCLES+1).
- A channel whose `active` is first seen low at edge Ek is captured at edge Ek+1. halt_cycle[i] = k+1.
- `done` rises at the edge after the last capture or the timeout edge, and is high for exactly one cycle.
- Final capture and timeout on the same edge: capture wins, and timeout stays 0.
- `reset` asserted mid-run: all outputs take reset values immediately. `reset` release is not a start.

## Configuration
- `RUN_MONITOR_HALT_CYCLE_EN` defined: the per-channel halt_cycle registers are built as specified above.
- `RUN_MONITOR_HALT_CYCLE_EN` undefined: no halt_cycle registers exist, and `halt_cycle` is tied to 0. All other behaviour is identical.

## Test plan
- Halt: N_CH=1, RESET_CYCLES=1. CPU model drops `active` 10 cycles after `cpu_reset` falls, with v0=0x0000_1234.
  - Required: `done` pulses once, halted=1, result_v0=0x1234, timeout=0, halt_cycle=13.
- Timeout: TIMEOUT_CYCLES=20 and `active` held at 1.
  - Required: timeout=1, `done` at cycle_count=19, halted=0, result_v0=0, `cpu_clk_enable`=0 in DONE.
- No active: `active`=0 throughout.
  - Required: no_active_err=1, halted=1, result_v0 equals the v0 present one cycle after WAIT_ACTIVE, timeout=0.
- Two channels: N_CH=2, halts staggered at 5 and 12 cycles after reset release, v0 = 0xA and 0xB.
  - Required: both values captured, halt_cycle = {15,8}, a single `done` after the second capture.
- Reset mid-run: drive `reset` low during RUN.
  - Required: `busy`=0, `cpu_reset`=1, results 0 before the next edge. No `done` after release until a new `start`.
- Start handling: pulse `start` during RUN, then again in DONE.
  - Required: the first pulse has no effect. The second clears halted/result_v0 and reruns the identical sequence.
